output_requant_fifo: RTL and testbench

//  Downstream stage of the convolution controller. It captures each finished output-pixel

---
 rtl/output_requant_fifo.sv | 146 ++++++++++++++
 tb/tb_output_requant_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_requant_fifo.sv
// -----------------------------------------------------------------------------
// output_requant_fifo
//
// Captures finished output-pixel accumulations from the convolution controller,
// requantizes each one from ACC_WIDTH to OUT_WIDTH (rounding arithmetic right
// shift, then saturation) and buffers the result in a small show-ahead FIFO
// that drains over a valid/ready handshake. The controller cannot be stalled,
// so a result that arrives while the FIFO is full is dropped and a sticky
// overflow flag is raised.
//
// Ports
//   clk, arst_n_in            clock (rising edge), async active-low reset
//   in_valid                  one-cycle result strobe (no ready)
//   in_data                   signed accumulator value
//   in_x, in_y, in_ch         coordinates of the result
//   out_valid, out_ready      head-entry handshake
//   out_data                  requantized head result (0 while empty)
//   out_x, out_y, out_ch      head coordinates (0 while empty)
//   fifo_count                number of occupied entries
//   overflow, clear_overflow  sticky drop flag and its synchronous clear
// -----------------------------------------------------------------------------
module output_requant_fifo #(
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int COORD_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          in_valid,
  input  logic [ACC_WIDTH-1:0]          in_data,
  input  logic [COORD_WIDTH-1:0]        in_x,
  input  logic [COORD_WIDTH-1:0]        in_y,
  input  logic [COORD_WIDTH-1:0]        in_ch,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [COORD_WIDTH-1:0]        out_x,
  output logic [COORD_WIDTH-1:0]        out_y,
  output logic [COORD_WIDTH-1:0]        out_ch,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EXT_W = ACC_WIDTH + 1;

  // Half an LSB of the shifted result; collapses to 0 when SHIFT is 0.
  localparam logic signed [EXT_W-1:0] ROUND_CONST = (EXT_W'(1) << SHIFT) >> 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [OUT_WIDTH-1:0]   data;
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [COORD_WIDTH-1:0] ch;
  } entry_t;

  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               push;
  logic               pop;
  logic               drop;

  // ---------------------------------------------------------------------------
  // Write-side requantization
  // ---------------------------------------------------------------------------
  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;
  logic [OUT_WIDTH-1:0]    sat_data;

  // One extra bit of headroom so the rounding add cannot wrap at +max.
  assign acc_ext = {in_data[ACC_WIDTH-1], in_data};
  assign rounded = acc_ext + ROUND_CONST;
  assign shifted = rounded >>> SHIFT;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sat_data = shifted[OUT_WIDTH-1:0];
    if (shifted > SAT_MAX)      sat_data = SAT_MAX[OUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) sat_data = SAT_MIN[OUT_WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && !push;

  always_ff @(posedge clk or negedge arst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (!arst_n_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear request wins.
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: sat_data, x: in_x, y: in_y, ch: in_ch};
  end

  assign fifo_count = count;

  // Show-ahead read: head entry is presented combinationally, zeros when empty.
  always_comb begin
    out_data = '0;
    out_x    = '0;
    out_y    = '0;
    out_ch   = '0;
    if (out_valid) begin
      out_data = mem[rd_ptr].data;
      out_x    = mem[rd_ptr].x;
      out_y    = mem[rd_ptr].y;
      out_ch   = mem[rd_ptr].ch;
    end
  end

endmodule

// File: tb/tb_output_requant_fifo.sv
// -----------------------------------------------------------------------------
// tb_output_requant_fifo
//
// Scoreboard bench. A model process decides, from the FIFO occupancy it keeps
// as a queue, whether each strobe is accepted or dropped and pushes the
// arithmetically requantized expectation. A monitor process pops and compares
// whenever the DUT completes a handshake. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_output_requant_fifo;

  localparam int ACC_WIDTH   = 32;
  localparam int OUT_WIDTH   = 16;
  localparam int SHIFT       = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int COORD_WIDTH = 32;

  typedef struct {
    longint data;
    longint x;
    longint y;
    longint ch;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        arst_n_in;
  logic                        in_valid;
  logic [ACC_WIDTH-1:0]        in_data;
  logic [COORD_WIDTH-1:0]      in_x, in_y, in_ch;
  logic                        out_valid;
  logic                        out_ready;
  logic [OUT_WIDTH-1:0]        out_data;
  logic [COORD_WIDTH-1:0]      out_x, out_y, out_ch;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        overflow;
  logic                        clear_overflow;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  bit   exp_ovf = 1'b0;

  output_requant_fifo #(
    .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT),
    .FIFO_DEPTH(FIFO_DEPTH), .COORD_WIDTH(COORD_WIDTH)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in),
    .in_valid(in_valid), .in_data(in_data),
    .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
    .fifo_count(fifo_count), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // round(d / 2^SHIFT) with halves toward +inf, then clamp to OUT_WIDTH signed.
  function automatic longint requant(input longint d);
    longint div, n, q, hi, lo;
    div = longint'(1) << SHIFT;
    n   = d + div / 2;
    q   = n / div;
    if (n < 0 && (n % div) != 0) q = q - 1;
    hi  = (longint'(1) << (OUT_WIDTH - 1)) - 1;
    lo  = -(longint'(1) << (OUT_WIDTH - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  // Model: runs after the monitor has popped this cycle, so free space in
  // exp_q already accounts for a simultaneous pop.
  always @(negedge clk) begin
    #1;
    if (arst_n_in && in_valid) begin
      if (exp_q.size() < FIFO_DEPTH) begin
        exp_t e;
        e.data = requant(longint'($signed(in_data)));
        e.x    = longint'(in_x);
        e.y    = longint'(in_y);
        e.ch   = longint'(in_ch);
        exp_q.push_back(e);
        if (clear_overflow) exp_ovf = 1'b0;
      end else begin
        exp_ovf = 1'b1;
      end
    end else if (arst_n_in && clear_overflow) begin
      exp_ovf = 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (arst_n_in) begin
      check("count", longint'(fifo_count), longint'(exp_q.size()));
      check("out_valid", longint'(out_valid), longint'(exp_q.size() != 0));
      check("overflow", longint'(overflow), longint'(exp_ovf));
      if (!out_valid) begin
        check("empty_data_zero", longint'(out_data), 0);
        check("empty_x_zero", longint'(out_x), 0);
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", longint'($signed(out_data)), e.data);
          check("out_x", longint'(out_x), e.x);
          check("out_y", longint'(out_y), e.y);
          check("out_ch", longint'(out_ch), e.ch);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] d, input int x);
    in_valid = 1'b1;
    in_data  = d;
    in_x     = x;
    in_y     = x + 100;
    in_ch    = x + 200;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      cyc();
      n++;
    end
    check("drain_done", longint'(exp_q.size()), 0);
  endtask

  initial begin
    arst_n_in = 1'b0;
    in_valid = 1'b0; in_data = '0; in_x = '0; in_y = '0; in_ch = '0;
    out_ready = 1'b0; clear_overflow = 1'b0;
    #12;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_count", longint'(fifo_count), 0);
    check("rst_overflow", longint'(overflow), 0);
    check("rst_out_data", longint'(out_data), 0);
    #11 arst_n_in = 1'b1;
    cyc();

    // 1: latency and rounding (3.5 -> 4)
    out_ready = 1'b1;
    strobe(32'h0000_0380, 7);
    @(negedge clk);
    check("lat_valid", longint'(out_valid), 1);
    check("lat_data", longint'($signed(out_data)), 4);
    check("lat_count", longint'(fifo_count), 1);
    cyc();
    @(negedge clk);
    check("lat_count_after", longint'(fifo_count), 0);
    cyc();

    // 2: saturation and negative rounding
    out_ready = 1'b0;
    strobe(32'h7FFF_FFFF, 1);
    @(negedge clk);
    check("sat_pos", longint'(out_data), 32'h7FFF);
    drain();
    out_ready = 1'b0;
    strobe(32'h8000_0000, 2);
    @(negedge clk);
    check("sat_neg", longint'(out_data), 32'h8000);
    drain();
    out_ready = 1'b0;
    strobe(-32'sd384, 3);
    @(negedge clk);
    check("neg_round", longint'($signed(out_data)), -1);
    drain();

    // 3: fill and overflow, x=4 dropped
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) strobe($urandom, i);
    @(negedge clk);
    check("fill_count", longint'(fifo_count), 4);
    check("fill_overflow", longint'(overflow), 1);
    cyc();
    drain();
    clear_overflow = 1'b1;
    cyc();
    clear_overflow = 1'b0;

    // 4: push and pop together while full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe($urandom, 10 + i);
    out_ready = 1'b1;
    strobe($urandom, 14);
    out_ready = 1'b0;
    @(negedge clk);
    check("full_pp_count", longint'(fifo_count), 4);
    check("full_pp_overflow", longint'(overflow), 0);
    cyc();
    drain();

    // 5: wrap with random out_ready
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      strobe($urandom, 20 + i);
      out_ready = 1'b1;
      cyc();
      check("wrap_bound", longint'(fifo_count <= FIFO_DEPTH), 1);
    end
    drain();

    // 6: overflow set wins over clear, then clear, then async reset
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe($urandom, 40 + i);
    clear_overflow = 1'b1;
    strobe($urandom, 44);
    clear_overflow = 1'b0;
    @(negedge clk);
    check("set_wins", longint'(overflow), 1);
    cyc();
    clear_overflow = 1'b1;
    cyc();
    clear_overflow = 1'b0;
    @(negedge clk);
    check("cleared", longint'(overflow), 0);
    cyc();
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) strobe($urandom, 50 + i);
    #2 arst_n_in = 1'b0;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_count", longint'(fifo_count), 0);
    exp_q.delete();
    exp_ovf = 1'b0;
    @(posedge clk);
    #3 arst_n_in = 1'b1;
    cyc();

    // Random soak
    for (int i = 0; i < 1500; i++) begin
      in_valid       = ($urandom_range(0, 99) < 60);
      in_data        = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) in_data = -in_data;
      in_x           = $urandom;
      in_y           = $urandom;
      in_ch          = $urandom;
      out_ready      = ($urandom_range(0, 99) < 55);
      clear_overflow = ($urandom_range(0, 99) < 5);
      cyc();
    end
    in_valid = 1'b0;
    clear_overflow = 1'b0;
    drain();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
